// File: rtl/e1_rx_buf_fifo.sv
// Elastic FIFO between the E1 RX deframer and the buffer unit write port.
// On overflow, whole multiframes are dropped until the next multiframe start.
module e1_rx_buf_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned MFW        = 7,
  parameter int unsigned START_SYNC = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic [4:0]            in_ts,
  input  logic [3:0]            in_frame,
  input  logic [MFW-1:0]        in_mf,
  input  logic                  in_stb,
  output logic [7:0]            buf_rx_data,
  output logic [4:0]            buf_rx_ts,
  output logic [3:0]            buf_rx_frame,
  output logic [MFW-1:0]        buf_rx_mf,
  output logic                  buf_rx_we,
  input  logic                  buf_rx_rdy,
  output logic [DEPTH_LOG2:0]   level,
  output logic [15:0]           ovf_cnt,
  output logic                  ovf_sticky,
  input  logic                  ovf_clr
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned EntryW = 8 + 5 + 4 + MFW;
  localparam logic [DEPTH_LOG2:0] LvlFull = (DEPTH_LOG2 + 1)'(Depth);

  typedef enum logic [1:0] {StSync, StRun, StDrop} state_e;

  state_e                  state_q;
  logic [EntryW-1:0]       mem [Depth];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     level_q;
  logic [15:0]             ovf_cnt_q;
  logic                    ovf_sticky_q;

  logic pop, push_ok, mf_start, accept, drop;

  assign pop      = (level_q != '0) & buf_rx_rdy;
  assign push_ok  = in_stb & ((level_q < LvlFull) | pop);
  assign mf_start = in_stb & (in_ts == 5'd0) & (in_frame == 4'd0);

  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    unique case (state_q)
      StSync: accept = mf_start & push_ok;
      StRun: begin
        accept = push_ok;
        drop   = in_stb & ~push_ok;
      end
      StDrop: begin
        accept = mf_start & push_ok;
        drop   = in_stb & ~(mf_start & push_ok);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr_q] <= {in_data, in_ts, in_frame, in_mf};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= (START_SYNC != 0) ? StSync : StRun;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      ovf_cnt_q    <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !pop)      level_q <= level_q + 1'b1;
      else if (!accept && pop) level_q <= level_q - 1'b1;

      unique case (state_q)
        StSync:  if (accept) state_q <= StRun;
        StRun:   if (drop)   state_q <= StDrop;
        StDrop:  if (accept) state_q <= StRun;
        default: state_q <= StRun;
      endcase

      // A drop in the same cycle as a clear leaves a count of one.
      if (drop) begin
        ovf_sticky_q <= 1'b1;
        if (ovf_clr)                   ovf_cnt_q <= 16'd1;
        else if (ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      end else if (ovf_clr) begin
        ovf_sticky_q <= 1'b0;
        ovf_cnt_q    <= '0;
      end
    end
  end

  assign {buf_rx_data, buf_rx_ts, buf_rx_frame, buf_rx_mf} =
      (level_q != '0) ? mem[rd_ptr_q] : '0;
  assign buf_rx_we  = pop;
  assign level      = level_q;
  assign ovf_cnt    = ovf_cnt_q;
  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_e1_rx_buf_fifo.sv
// Randomized and directed bench for e1_rx_buf_fifo against a queue-based model.
module tb_e1_rx_buf_fifo;

  localparam int MFW = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     in_data;
  logic [4:0]     in_ts;
  logic [3:0]     in_frame;
  logic [MFW-1:0] in_mf;
  logic           in_stb;
  logic [7:0]     buf_rx_data;
  logic [4:0]     buf_rx_ts;
  logic [3:0]     buf_rx_frame;
  logic [MFW-1:0] buf_rx_mf;
  logic           buf_rx_we;
  logic           buf_rx_rdy;
  logic [4:0]     level;
  logic [15:0]    ovf_cnt;
  logic           ovf_sticky;
  logic           ovf_clr;

  e1_rx_buf_fifo #(.DEPTH_LOG2(4), .MFW(MFW), .START_SYNC(1)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_ts(in_ts), .in_frame(in_frame), .in_mf(in_mf), .in_stb(in_stb),
    .buf_rx_data(buf_rx_data), .buf_rx_ts(buf_rx_ts), .buf_rx_frame(buf_rx_frame),
    .buf_rx_mf(buf_rx_mf), .buf_rx_we(buf_rx_we), .buf_rx_rdy(buf_rx_rdy),
    .level(level), .ovf_cnt(ovf_cnt), .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: queue of octets, a mode (0 waiting for sync, 1 running, 2 dropping), counters.
  logic [23:0] q[$];
  int          mode;
  int          m_cnt;
  bit          m_sticky;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode     = 0;
    m_cnt    = 0;
    m_sticky = 0;
  endtask

  // Drive one cycle of inputs, check combinational outputs, clock, check state.
  task automatic step(input bit stb, input logic [7:0] d, input logic [4:0] t,
                      input logic [3:0] f, input logic [MFW-1:0] m, input bit r, input bit c);
    logic [23:0] head;
    bit pop, room, mfs, acc, drp;
    in_stb = stb; in_data = d; in_ts = t; in_frame = f; in_mf = m;
    buf_rx_rdy = r; ovf_clr = c;
    #1;
    head = (q.size() != 0) ? q[0] : 24'd0;
    pop  = (q.size() != 0) && r;
    chk("we", 32'(buf_rx_we), 32'(pop));
    chk("head", {8'd0, buf_rx_data, buf_rx_ts, buf_rx_frame, buf_rx_mf}, 32'(head));
    room = stb && (q.size() < 16 || pop);
    mfs  = stb && t == 0 && f == 0;
    acc  = 0;
    drp  = 0;
    if (mode == 0) begin
      if (mfs && room) begin acc = 1; mode = 1; end
    end else if (mode == 1) begin
      if (room) acc = 1;
      else if (stb) begin drp = 1; mode = 2; end
    end else begin
      if (mfs && room) begin acc = 1; mode = 1; end
      else if (stb) drp = 1;
    end
    if (pop) void'(q.pop_front());
    if (acc) q.push_back({d, t, f, m});
    if (drp) begin
      m_sticky = 1;
      m_cnt = c ? 1 : (m_cnt < 65535 ? m_cnt + 1 : 65535);
    end else if (c) begin
      m_sticky = 0;
      m_cnt = 0;
    end
    @(posedge clk);
    #1;
    in_stb = 0;
    ovf_clr = 0;
    chk("level", 32'(level), 32'(q.size()));
    chk("ovf_cnt", 32'(ovf_cnt), 32'(m_cnt));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
  endtask

  task automatic idle(input bit r);
    step(0, 8'd0, 5'd0, 4'd0, 7'd0, r, 0);
  endtask

  initial begin
    rst = 1; in_stb = 0; in_data = 0; in_ts = 0; in_frame = 0; in_mf = 0;
    buf_rx_rdy = 0; ovf_clr = 0;
    model_reset();
    #1;
    chk("rst_level", 32'(level), 0);
    chk("rst_we", 32'(buf_rx_we), 0);
    chk("rst_cnt", 32'(ovf_cnt), 0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // Pass-through with initial sync.
    step(1, 8'h11, 5'd5, 4'd0, 7'd1, 1, 0);
    chk("sync_discard", 32'(level), 0);
    step(1, 8'h34, 5'd0, 4'd0, 7'd3, 1, 0);
    #0;
    chk("pt_we", 32'(buf_rx_we), 1);
    chk("pt_data", 32'(buf_rx_data), 32'h34);
    chk("pt_mf", 32'(buf_rx_mf), 3);
    idle(1);
    chk("pt_empty", 32'(level), 0);

    // Fill and overflow.
    for (int i = 0; i < 17; i++) step(1, 8'(i + 8'h40), 5'(i), 4'd2, 7'd4, 0, 0);
    chk("full_level", 32'(level), 16);
    chk("ovf1_cnt", 32'(ovf_cnt), 1);
    chk("ovf1_sticky", 32'(ovf_sticky), 1);
    for (int i = 17; i < 32; i++) step(1, 8'(i), 5'(i), 4'd2, 7'd4, 0, 0);
    chk("ovf16_cnt", 32'(ovf_cnt), 16);

    // Drain and resync.
    for (int i = 0; i < 16; i++) idle(1);
    chk("drained", 32'(level), 0);
    step(1, 8'h55, 5'd0, 4'd1, 7'd5, 1, 0);
    chk("resync_cnt", 32'(ovf_cnt), 17);
    step(1, 8'h66, 5'd0, 4'd0, 7'd6, 1, 0);
    chk("resync_data", 32'(buf_rx_data), 32'h66);
    idle(1);

    // Full with simultaneous pop.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 5'(i + 1), 4'd3, 7'd7, 0, 0);
    step(1, 8'hA5, 5'd20, 4'd3, 7'd7, 1, 0);
    chk("fullpop_level", 32'(level), 16);
    chk("fullpop_cnt", 32'(ovf_cnt), 17);

    // Clear colliding with a counted drop, then clear alone.
    step(1, 8'hBB, 5'd21, 4'd3, 7'd7, 0, 1);
    chk("clr_coll_cnt", 32'(ovf_cnt), 1);
    chk("clr_coll_sticky", 32'(ovf_sticky), 1);
    step(0, 8'd0, 5'd0, 4'd0, 7'd0, 0, 1);
    chk("clr_cnt", 32'(ovf_cnt), 0);
    chk("clr_sticky", 32'(ovf_sticky), 0);

    // Saturation.
    for (int i = 0; i < 65540; i++) step(1, 8'(i), 5'd9, 4'd1, 7'd0, 0, 0);
    chk("sat_cnt", 32'(ovf_cnt), 32'hFFFF);

    // Drain, resync, build level 9, then reset mid-stream.
    for (int i = 0; i < 16; i++) idle(1);
    step(1, 8'h77, 5'd0, 4'd0, 7'd8, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 8'(i), 5'(i + 1), 4'd0, 7'd8, 0, 0);
    chk("pre_rst_level", 32'(level), 9);
    buf_rx_rdy = 1;
    #2;
    rst = 1;
    #1;
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_we", 32'(buf_rx_we), 0);
    chk("mid_rst_cnt", 32'(ovf_cnt), 0);
    chk("mid_rst_data", {8'd0, buf_rx_data, buf_rx_ts, buf_rx_frame, buf_rx_mf}, 0);
    model_reset();
    @(posedge clk); #1; rst = 0;
    step(1, 8'h12, 5'd3, 4'd0, 7'd9, 1, 0);
    step(1, 8'h99, 5'd0, 4'd0, 7'd9, 0, 0);
    chk("post_rst_data", 32'(buf_rx_data), 32'h99);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      bit s, r, c, z;
      s = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 40) == 0);
      z = ($urandom_range(0, 5) == 0);
      step(s, 8'($urandom), z ? 5'd0 : 5'($urandom), z ? 4'd0 : 4'($urandom),
           7'($urandom), r, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
